// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-entry AXI-Stream holding register.
// The line is double-flopped, each bit is sampled once at mid-bit, and good
// bytes, stop-bit failures and dropped bytes are reported as one-cycle pulses.
//
// Handshake: o_m_axis_tdata is transferred on any i_clk edge where
// o_m_axis_tvalid and i_m_axis_tready are both high. Once tvalid is raised,
// tvalid and tdata hold steady until that transfer edge. A byte may be loaded
// on the same edge that the previous one is transferred.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rxd,
    output logic       o_m_axis_tvalid,
    input  logic       i_m_axis_tready,
    output logic [7:0] o_m_axis_tdata,
    output logic       o_rxd_busy,
    output logic       o_rxd_done,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic [2:0] o_dbg_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        WAIT_HIGH = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        RXDATA    = 3'd3,
        STOP      = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          load, drop, ferr;
    logic          rxd_meta, rxs;
    logic          hold_free;

    // The holding register can take a byte if empty or being drained this edge.
    assign hold_free   = !o_m_axis_tvalid || i_m_axis_tready;
    assign o_dbg_state = state;

    // Two-flop synchronizer on the asynchronous serial line.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rxd_meta <= 1'b0;
            rxs      <= 1'b0;
        end else begin
            rxd_meta <= i_rxd;
            rxs      <= rxd_meta;
        end
    end

    // Next-state logic: bit timing, sampling and end-of-frame decisions.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        load    = 1'b0;
        drop    = 1'b0;
        ferr    = 1'b0;
        case (state)
            WAIT_HIGH: begin
                // A full bit period of idle must be seen before arming.
                if (rxs) begin
                    if (cnt == LAST) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end else begin
                    cnt_n = '0;
                end
            end
            IDLE: begin
                cnt_n = '0;
                if (!rxs) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    // A line already back high at mid-start is a glitch.
                    state_n = rxs ? IDLE : RXDATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RXDATA: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    shift_n = {rxs, shift[7:1]};
                    bit_n   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (rxs) begin
                        // Leaving at mid-stop gives half a bit to catch the next start edge.
                        state_n = IDLE;
                        if (hold_free) begin
                            load = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                    end else begin
                        ferr    = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = WAIT_HIGH;
                cnt_n   = '0;
                bit_n   = '0;
            end
        endcase
    end

    // Frame state, bit timing counter, bit index and shift register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= WAIT_HIGH;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
        end
    end

    // Holding register, registered status pulses and busy flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_m_axis_tvalid <= 1'b0;
            o_m_axis_tdata  <= 8'h00;
            o_rxd_done      <= 1'b0;
            o_frame_err     <= 1'b0;
            o_overrun       <= 1'b0;
            o_rxd_busy      <= 1'b0;
        end else begin
            if (load) begin
                o_m_axis_tvalid <= 1'b1;
                o_m_axis_tdata  <= shift;
            end else if (i_m_axis_tready) begin
                o_m_axis_tvalid <= 1'b0;
            end
            o_rxd_done  <= load;
            o_frame_err <= ferr;
            o_overrun   <= drop;
            o_rxd_busy  <= (state_n == START) || (state_n == RXDATA) || (state_n == STOP);
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver: 8 data bits, LSB first, one start bit, one stop bit, no parity. It sits on the line side opposite the transmitter and delivers each received byte on an AXI-Stream master port with a one-entry holding register. It also flags framing errors and overruns. The input line is double-flopped, and every bit is sampled once at mid-bit.

## Interface
- CLKS_PER_BIT, 16, i_clk cycles per UART bit; legal range ≥ 4. Counter width is $clog2(CLKS_PER_BIT).
- i_clk  in  1  single clock domain
- i_rst_n  in  1  asynchronous, active-low reset
- i_rxd  in  1  asynchronous serial line; idles high
- o_m_axis_tvalid  out  1  received byte available
- i_m_axis_tready  in  1  downstream accepts byte
- o_m_axis_tdata  out  8  received byte; bit 0 is the first bit on the wire
- o_rxd_busy  out  1  high while a frame is in progress (START, RXDATA, STOP)
- o_rxd_done  out  1  one-cycle pulse when a good byte is loaded into the holding register
- o_frame_err  out  1  one-cycle pulse when the stop bit is sampled low
- o_overrun  out  1  one-cycle pulse when a good byte is dropped because the holding register is full

## Operation
- **Synchronizer:** two flops on i_rxd, both reset to 0. All logic uses the second flop, rxs.
- **Half-bit point:** H = (CLKS_PER_BIT-1)/2, integer division.
- **States:** WAIT_HIGH, IDLE, START, RXDATA, STOP. The reset state is WAIT_HIGH.
- **WAIT_HIGH:**
  - Counts consecutive cycles with rxs=1; the counter clears on rxs=0.
  - When count reaches CLKS_PER_BIT-1 with rxs=1 → IDLE.
  - Purpose: guarantees a full idle bit period after reset or a break/framing error before any start bit is accepted.
- **IDLE:** rxs=0 → START, with the counter cleared.
- **START:**
  - Counter increments each cycle.
  - At count==H: rxs=0 → RXDATA, counter cleared, bit index cleared.
  - At count==H with rxs=1: treat as a glitch → IDLE. No error pulse.
- **RXDATA:**
  - At count==CLKS_PER_BIT-1 (mid-bit), sample and shift: shift <= {rxs, shift[7:1]}. Counter cleared, bit index increments.
  - After bit index 7 is sampled → STOP.
- **STOP:** at count==CLKS_PER_BIT-1, sample rxs.
  - rxs=1, holding register free: load the byte, pulse o_rxd_done → IDLE. This leaves the remaining half of the stop bit for start-edge resynchronisation.
  - rxs=1, holding register full: pulse o_overrun, drop the new byte, keep the old byte → IDLE.
  - rxs=0: pulse o_frame_err, discard the byte → WAIT_HIGH.
- **Holding register:**
  - "Free" means tvalid=0, or tvalid=1 and tready=1 on the same edge. Simultaneous drain and load produces no overrun.
  - tvalid sets on load and clears on a tvalid&&tready edge with no load.
  - tdata is stable while tvalid=1. tvalid never deasserts without a handshake.
- **Illegal state encoding:** → WAIT_HIGH.

## Timing
- **Reset values:**
  - tvalid=0, tdata=0x00
  - busy=0, done=0, frame_err=0, overrun=0
  - state=WAIT_HIGH, counters=0, shift=0
- **Reset mid-frame:** the partial byte is lost. The holding register is cleared, even if it held an unread byte.
- **Latency:**
  - Let E0 be the first i_clk edge at which i_rxd is low.
  - rxs is low after edge E1. IDLE moves to START at E2.
  - START exit is at E(3+H). Data bit k is sampled at E(3+H+(k+1)·CLKS_PER_BIT).
  - The stop bit is sampled, and tvalid/done asserted, at E(3+H+9·CLKS_PER_BIT). For CLKS_PER_BIT=16 this is E154.
- **After reset release:** the first frame can be recognised only after 2 + CLKS_PER_BIT cycles of line high. For CLKS_PER_BIT=16 that is 18 cycles.
- **Pulse outputs:** done, frame_err and overrun are registered, last exactly one cycle, and are mutually exclusive.
- **busy:** rises the cycle after IDLE→START and falls the cycle after the STOP exit.
- **Back-to-back frames:** frames with zero idle between stop and start are received without loss at nominal baud.
- **Baud tolerance:** at least ±3 % mismatch, with the sample point at mid-bit.

## Test plan
- **Single byte:** CLKS_PER_BIT=16, idle 40 cycles, send 0xA5 with tready=1 → tdata=0xA5, tvalid high for 1 cycle at E154 from the start edge, done=1 for 1 cycle, no error pulses.
- **Back-to-back with backpressure:**
  - Send 0x00, 0xFF, 0x3C back-to-back with tready held 0 → 0x00 held with tvalid=1.
  - overrun pulses once each for 0xFF and 0x3C.
  - Raising tready then drains 0x00 only.
- **Drain on load edge:** hold 0x11, then assert tready on exactly the edge 0x22's stop bit is sampled → no overrun, 0x22 presented the next cycle.
- **Framing error and glitch rejection:**
  - Send 0x55 with stop bit low, then the line high for 10 cycles, then a valid 0x66 → frame_err pulse, no tvalid. 0x66 is rejected until a full 16-cycle high period has elapsed; after 16+ high cycles, 0x66 is received.
  - A 5-cycle low glitch on an idle line → no busy beyond START, no output.
- **Reset mid-frame:** assert i_rst_n=0 during bit 3 of 0xC3 with an unread byte held → all outputs return to reset values immediately. A subsequent 0x81 after line idle is received correctly.
- **Baud mismatch:** CLKS_PER_BIT=16, transmitter at 15.5 clk/bit, bytes 0x01, 0x80, 0xAA → all received correctly.
